// File: rtl/modmult_arbiter.sv
// modmult_arbiter: round-robin sharing of one pipelined ModMult among NUM_REQ requesters
module modmult_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MM_LAT     = 8,
  parameter int ID_W       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cfg_q_we,
  input  logic [DATA_WIDTH-1:0]          cfg_q,
  output logic                           cfg_err,
  output logic [DATA_WIDTH-1:0]          mm_A,
  output logic [DATA_WIDTH-1:0]          mm_B,
  output logic [DATA_WIDTH-1:0]          mm_q,
  input  logic [DATA_WIDTH-1:0]          mm_C,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           idle
);
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, q_q;
  logic [ID_W-1:0] rr_q, rr_d, win, idx;
  logic acc;
  logic [MM_LAT-1:0] tv_q;
  logic [ID_W-1:0] tid_q [MM_LAT];
  logic [NUM_REQ-1:0] rsp_q, rsp_d;
  logic cfg_err_q;
  // first valid requester at or after rr_q wins; operands and tail decode follow
  always_comb begin
    win = '0;
    idx = '0;
    acc = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_q) + 32'(k)) % 32'(NUM_REQ));
      if (en && !acc && req_valid[idx]) begin
        acc = 1'b1;
        win = idx;
      end
    end
    req_ready = acc ? NUM_REQ'(1) << win : '0;
    a_d = acc ? req_a[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    b_d = acc ? req_b[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    rr_d = !acc ? rr_q : (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    rsp_d = tv_q[MM_LAT-1] ? NUM_REQ'(1) << tid_q[MM_LAT-1] : '0;
  end
  // idle needs the response register empty too, so q never changes under a product
  assign idle = ~|tv_q & ~|rsp_q & ~|req_valid;
  // operand, pointer, tag-valid and modulus registers; reset discards in-flight tags
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      q_q       <= '0;
      rr_q      <= '0;
      tv_q      <= '0;
      rsp_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      rr_q      <= rr_d;
      tv_q      <= {tv_q[MM_LAT-2:0], acc};
      rsp_q     <= rsp_d;
      cfg_err_q <= cfg_q_we && !idle;
      q_q       <= (cfg_q_we && idle) ? cfg_q : q_q;
    end
  end
  // requester ids ride alongside the valid bits; they only matter where valid is set
  always_ff @(posedge clk) begin
    tid_q[0] <= win;
    for (int k = 1; k < MM_LAT; k++) tid_q[k] <= tid_q[k-1];
  end
  assign mm_A      = a_q;
  assign mm_B      = b_q;
  assign mm_q      = q_q;
  assign cfg_err   = cfg_err_q;
  assign rsp_valid = rsp_q;
  assign rsp_data  = mm_C;
endmodule

// File: tb/tb_modmult_arbiter.sv
// tb_modmult_arbiter: randomized scoreboard bench for modmult_arbiter with a ModMult model
module tb_modmult_arbiter;
  localparam int DW = 32, N = 4, LAT = 8;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, cfg_q_we = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] cfg_q = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic cfg_err, idle;
  logic [DW-1:0] mm_A, mm_B, mm_q, mm_C, rsp_data;
  int checks = 0, failures = 0;
  typedef struct {int id; logic [DW-1:0] d; int due;} exp_t;
  exp_t sb[$];
  int glog[$], rlog[$];
  logic [DW-1:0] rdat[$];
  int cyc = 0, rr_m = 0;
  logic [DW-1:0] q_m = '0, a_m = '0, b_m = '0;
  bit err_m = 0, chk_on = 0;
  logic [DW-1:0] pipe [LAT];

  modmult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MM_LAT(LAT), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cfg_q_we(cfg_q_we), .cfg_q(cfg_q), .cfg_err(cfg_err),
    .mm_A(mm_A), .mm_B(mm_B), .mm_q(mm_q), .mm_C(mm_C), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .idle(idle));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= (mm_q == 0) ? '0 : DW'((64'(mm_A) * 64'(mm_B)) % 64'(mm_q));
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mm_C = pipe[LAT-1];

  always @(negedge clk) begin
    int g;
    bit eidle;
    logic [N-1:0] ersp, egnt;
    logic [DW-1:0] edat;
    cyc++;
    eidle = (sb.size() == 0) && (req_valid == 0);
    ersp = '0;
    edat = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      ersp = N'(1) << sb[0].id;
      edat = sb[0].d;
      void'(sb.pop_front());
    end
    if (rsp_valid != 0) begin
      for (int k = 0; k < N; k++) if (rsp_valid[k]) rlog.push_back(k);
      rdat.push_back(rsp_data);
    end
    if (reset && req_ready != 0)
      for (int k = 0; k < N; k++) if (req_ready[k]) glog.push_back(k);
    g = -1;
    if (en) for (int k = 0; k < N; k++) if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
    egnt = (g < 0) ? '0 : N'(1) << g;
    if (chk_on) begin
      checks++; if (rsp_valid !== ersp) begin failures++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ersp); end
      if (ersp != 0) begin checks++; if (rsp_data !== edat) begin failures++; $display("FAIL rsp_data cyc=%0d got=%0d exp=%0d", cyc, rsp_data, edat); end end
      checks++; if (idle !== eidle) begin failures++; $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, idle, eidle); end
      checks++; if (req_ready !== egnt) begin failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, egnt); end
      checks++; if (mm_A !== a_m || mm_B !== b_m) begin failures++; $display("FAIL mm_AB cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, mm_A, mm_B, a_m, b_m); end
      checks++; if (mm_q !== q_m) begin failures++; $display("FAIL mm_q cyc=%0d got=%0d exp=%0d", cyc, mm_q, q_m); end
      checks++; if (cfg_err !== err_m) begin failures++; $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, err_m); end
    end
    if (!reset) begin
      sb.delete();
      rr_m = 0; q_m = '0; a_m = '0; b_m = '0; err_m = 0;
    end else begin
      err_m = cfg_q_we && !eidle;
      if (cfg_q_we && eidle) q_m = cfg_q;
      if (g >= 0) begin
        a_m = req_a[g*DW +: DW];
        b_m = req_b[g*DW +: DW];
        sb.push_back('{g, (q_m == 0) ? '0 : DW'((64'(a_m) * 64'(b_m)) % 64'(q_m)), cyc + 1 + LAT});
        rr_m = (g + 1) % N;
      end else begin
        a_m = '0; b_m = '0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [DW-1:0] a, logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 7680), $urandom_range(0, 7680));
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(1); reset = 1'b1;
  endtask

  task automatic set_q(logic [DW-1:0] v);
    cfg_q_we = 1'b1; cfg_q = v; tick(1); cfg_q_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
    tick(1);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL drain pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; tick(3); reset = 1'b1; chk_on = 1; tick(1);
    checks++; if (mm_A !== 0 || mm_B !== 0 || mm_q !== 0) begin failures++; $display("FAIL reset_regs got=%0d,%0d,%0d exp=0,0,0", mm_A, mm_B, mm_q); end
    checks++; if (rsp_valid !== 0 || cfg_err !== 0) begin failures++; $display("FAIL reset_out got=%b,%b exp=0,0", rsp_valid, cfg_err); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
  endtask

  task automatic test_single();
    int n;
    bit found;
    set_q(7681);
    checks++; if (mm_q !== 7681) begin failures++; $display("FAIL single_q got=%0d exp=7681", mm_q); end
    set_op(1, 3, 5); req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    tick(1); req_valid = '0;
    n = 1; found = 0;
    while (n <= 20 && !found) begin
      @(negedge clk);
      if (rsp_valid != 0) found = 1;
      else begin tick(1); n++; end
    end
    checks++; if (!found || n != 9) begin failures++; $display("FAIL single_latency got=%0d exp=9", n); end
    checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 15) begin failures++; $display("FAIL single_rsp got=%b/%0d exp=0010/15", rsp_valid, rsp_data); end
    tick(1);
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
    tick(1);
  endtask

  task automatic test_fairness();
    do_reset(); set_q(7681);
    glog.delete(); rlog.delete(); rdat.delete();
    req_valid = 4'hf;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      if (c == 0) set_op(0, 7680, 7680);
      tick(1);
    end
    req_valid = '0;
    drain();
    checks++; if (glog.size() != 8 || rlog.size() != 8) begin failures++; $display("FAIL fair_count got=%0d,%0d exp=8,8", glog.size(), rlog.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++; if (glog[k] != k % 4 || rlog[k] != k % 4) begin failures++; $display("FAIL fair_order k=%0d got=%0d,%0d exp=%0d", k, glog[k], rlog[k], k % 4); end
    end
    checks++; if (rdat.size() == 0 || rdat[0] !== 1) begin failures++; $display("FAIL fair_7680sq got=%0d exp=1", rdat.size() ? rdat[0] : 'x); end
  endtask

  task automatic test_rotation();
    set_op(1, 11, 12); req_valid = 4'b0010; tick(1);
    glog.delete();
    req_valid = 4'b1011; rand_ops();
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rot_first got=%b exp=1000", req_ready); end
    tick(3); req_valid = '0;
    checks++; if (glog.size() != 3 || glog[0] != 3 || glog[1] != 0 || glog[2] != 1) begin failures++; $display("FAIL rot_seq got=%p exp=3,0,1", glog); end
    drain();
  endtask

  task automatic test_en_gating();
    int pre;
    rlog.delete();
    req_valid = 4'hf; rand_ops(); tick(2);
    en = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 0) begin failures++; $display("FAIL en_block got=%b exp=0000", req_ready); end
    pre = glog.size();
    tick(12);
    checks++; if (glog.size() != pre) begin failures++; $display("FAIL en_nogrant got=%0d exp=%0d", glog.size(), pre); end
    checks++; if (rlog.size() != 2) begin failures++; $display("FAIL en_delivered got=%0d exp=2", rlog.size()); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL en_resume got=%b exp=0001", req_ready); end
    tick(1); req_valid = '0;
    drain();
  endtask

  task automatic test_cfg_busy();
    set_op(2, 100, 200); req_valid = 4'b0100; tick(1); req_valid = '0; tick(1);
    set_q(12289);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1 || mm_q !== 7681) begin failures++; $display("FAIL cfg_busy got=%b/%0d exp=1/7681", cfg_err, mm_q); end
    for (int i = 0; i < 30 && idle !== 1'b1; i++) tick(1);
    set_q(12289);
    checks++; if (mm_q !== 12289 || cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_idle got=%0d/%b exp=12289/0", mm_q, cfg_err); end
    tick(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      en = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      rand_ops();
      tick(1);
    end
    req_valid = '0; en = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'hf; rand_ops(); tick(3);
    req_valid = '0; tick(1);
    do_reset();
    checks++; if (mm_A !== 0 || mm_B !== 0 || mm_q !== 0) begin failures++; $display("FAIL mid_regs got=%0d,%0d,%0d exp=0,0,0", mm_A, mm_B, mm_q); end
    rlog.delete();
    tick(15);
    checks++; if (rlog.size() != 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", rlog.size()); end
    req_valid = 4'hf; rand_ops();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first got=%b exp=0001", req_ready); end
    tick(1); req_valid = '0;
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_en_gating();
    test_cfg_busy();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
